// File: rtl/bus_reg_file.sv
// bus_reg_file: DEPTH x WIDTH general-purpose register bank for the CPU data bus.
// Supports load / increment / decrement of one addressed register per clock
// (priority wr_en > inc_en > dec_en), an addressed tri-state bus driver, an
// always-driven debug read port, a zero flag on the bus-read path and a sticky
// error flag for overlapping enables.
// Optional feature: define BUS_REG_FILE_BYPASS_EN to forward wr_data to the
// read ports when a load targets the register currently being read.
module bus_reg_file #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic             inc_en,
  input  logic             dec_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             oe,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] bus_out,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data,
  output logic             rd_zero,
  output logic             err_multi
);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic             err_multi_q;
  logic             err_multi_d;
  logic             multi_s;
  logic             wr_valid_s;
  logic [WIDTH-1:0] rd_val_s;
  logic [WIDTH-1:0] dbg_val_s;
  logic [WIDTH-1:0] rd_sel_s;
  logic [WIDTH-1:0] dbg_sel_s;

  // Next-state of the array: only the addressed register changes, by priority.
  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_addr == AW'(i)) begin
        if (wr_en) begin
          regs_d[i] = wr_data;
        end else if (inc_en) begin
          regs_d[i] = regs_q[i] + WIDTH'(1);
        end else if (dec_en) begin
          regs_d[i] = regs_q[i] - WIDTH'(1);
        end else begin
          regs_d[i] = regs_q[i];
        end
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
  end

  // Sticky overlap detector: any two of the three enables in the same cycle.
  always_comb begin
    multi_s     = (wr_en & inc_en) | (wr_en & dec_en) | (inc_en & dec_en);
    err_multi_d = err_multi_q | multi_s;
  end

  // Register array and error flag; asynchronous clear on rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= {WIDTH{1'b0}};
      end
      err_multi_q <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      err_multi_q <= err_multi_d;
    end
  end

  // Combinational read muxes; addresses with no backing register read as zero.
  always_comb begin
    rd_val_s   = {WIDTH{1'b0}};
    dbg_val_s  = {WIDTH{1'b0}};
    wr_valid_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      rd_val_s   = (rd_addr  == AW'(i)) ? regs_q[i] : rd_val_s;
      dbg_val_s  = (dbg_addr == AW'(i)) ? regs_q[i] : dbg_val_s;
      wr_valid_s = wr_valid_s | (wr_addr == AW'(i));
    end
  end

  // Optional same-cycle forwarding of a pending load onto the read ports.
  always_comb begin
`ifdef BUS_REG_FILE_BYPASS_EN
    rd_sel_s  = (wr_en && wr_valid_s && (rd_addr  == wr_addr)) ? wr_data : rd_val_s;
    dbg_sel_s = (wr_en && wr_valid_s && (dbg_addr == wr_addr)) ? wr_data : dbg_val_s;
`else
    rd_sel_s  = rd_val_s;
    dbg_sel_s = dbg_val_s;
`endif
  end

  assign bus_out   = oe ? rd_sel_s : {WIDTH{1'bz}};
  assign dbg_data  = dbg_sel_s;
  assign rd_zero   = (rd_sel_s == {WIDTH{1'b0}});
  assign err_multi = err_multi_q;

endmodule

// File: tb/tb_bus_reg_file.sv
// Scoreboard bench for bus_reg_file. Two instances (DEPTH=4 and DEPTH=3) share
// all inputs; the DEPTH=3 copy exercises out-of-range addresses. A stimulus
// process updates an array-based reference model at each rising edge, drives
// new inputs and queues the expected read-port values; a monitor on the
// falling edge pops and compares.
module tb_bus_reg_file;

  logic       clk;
  logic       rst_n;
  logic       wr_en, inc_en, dec_en, oe;
  logic [1:0] wr_addr, rd_addr, dbg_addr;
  logic [7:0] wr_data;
  logic [7:0] bus4, dbg4, bus3, dbg3;
  logic       z4, z3, err4, err3;

  bus_reg_file #(.WIDTH(8), .DEPTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .inc_en(inc_en), .dec_en(dec_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .oe(oe), .rd_addr(rd_addr),
    .bus_out(bus4), .dbg_addr(dbg_addr), .dbg_data(dbg4), .rd_zero(z4),
    .err_multi(err4)
  );

  bus_reg_file #(.WIDTH(8), .DEPTH(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .inc_en(inc_en), .dec_en(dec_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .oe(oe), .rd_addr(rd_addr),
    .bus_out(bus3), .dbg_addr(dbg_addr), .dbg_data(dbg3), .rd_zero(z3),
    .err_multi(err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         step;
    logic [7:0] bus4, dbg4, bus3, dbg3;
    logic       z4, z3, err;
  } exp_t;

  exp_t       sb_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] m4 [4];
  logic [7:0] m3 [3];
  logic       m_err;

  // Stimulus vector: rst_n, wr, inc, dec, waddr, wdata, oe, raddr, daddr
  typedef struct {
    logic       rst_n, wr, inc, dec;
    logic [1:0] wa;
    logic [7:0] wd;
    logic       oe;
    logic [1:0] ra, da;
  } stim_t;

  function automatic logic [7:0] next_val(logic [7:0] v);
    if (wr_en)  return wr_data;
    if (inc_en) return 8'((int'(v) + 1) % 256);
    if (dec_en) return 8'((int'(v) + 255) % 256);
    return v;
  endfunction

  // Reference model of one rising edge, using the inputs present at the edge.
  task automatic model_edge();
    int a;
    int n;
    if (!rst_n) return;
    n = int'(wr_en) + int'(inc_en) + int'(dec_en);
    if (n >= 2) m_err = 1'b1;
    a = int'(wr_addr);
    if (a < 4) m4[a] = next_val(m4[a]);
    if (a < 3) m3[a] = next_val(m3[a]);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) m4[i] = 8'h00;
    for (int i = 0; i < 3; i++) m3[i] = 8'h00;
    m_err = 1'b0;
  endtask

  function automatic logic [7:0] exp_rd(int depth, logic [1:0] a);
    if (int'(a) >= depth) return 8'h00;
`ifdef BUS_REG_FILE_BYPASS_EN
    if (wr_en && (a == wr_addr)) return wr_data;
`endif
    return (depth == 4) ? m4[a] : m3[a];
  endfunction

  task automatic apply(input stim_t s, input int step);
    exp_t e;
    rst_n = s.rst_n; wr_en = s.wr; inc_en = s.inc; dec_en = s.dec;
    wr_addr = s.wa; wr_data = s.wd; oe = s.oe; rd_addr = s.ra; dbg_addr = s.da;
    if (!s.rst_n) model_clear();
    e.step = step;
    e.bus4 = oe ? exp_rd(4, rd_addr) : 8'bzzzz_zzzz;
    e.bus3 = oe ? exp_rd(3, rd_addr) : 8'bzzzz_zzzz;
    e.dbg4 = exp_rd(4, dbg_addr);
    e.dbg3 = exp_rd(3, dbg_addr);
    e.z4   = (exp_rd(4, rd_addr) == 8'h00);
    e.z3   = (exp_rd(3, rd_addr) == 8'h00);
    e.err  = m_err;
    sb_q.push_back(e);
  endtask

  task automatic chk(input string name, input int step, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
    end
  endtask

  // Monitor: compare every queued expectation against the sampled outputs.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk("bus_out4",   e.step, bus4, e.bus4);
      chk("dbg_data4",  e.step, dbg4, e.dbg4);
      chk("rd_zero4",   e.step, {7'd0, z4}, {7'd0, e.z4});
      chk("err_multi4", e.step, {7'd0, err4}, {7'd0, e.err});
      chk("bus_out3",   e.step, bus3, e.bus3);
      chk("dbg_data3",  e.step, dbg3, e.dbg3);
      chk("rd_zero3",   e.step, {7'd0, z3}, {7'd0, e.z3});
      chk("err_multi3", e.step, {7'd0, err3}, {7'd0, e.err});
    end
  end

  stim_t dir [14];

  initial begin
    stim_t s;
    int    step;
    int    wait_cnt;
    //           rst  wr    inc   dec   wa     wd     oe    ra     da
    dir[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 8'h5A, 1'b0, 2'd1, 2'd1};
    dir[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd1, 2'd1};
    dir[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 8'hC3, 1'b0, 2'd1, 2'd1};
    dir[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 2'd0};
    dir[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd2, 2'd2};
    dir[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'hFF, 1'b1, 2'd0, 2'd0};
    dir[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 2'd0};
    dir[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 8'h00, 1'b1, 2'd0, 2'd0};
    dir[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 2'd0};
    dir[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 8'h10, 1'b1, 2'd1, 2'd1};
    dir[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 2'd1};
    dir[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 8'h77, 1'b1, 2'd3, 2'd3};
    dir[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 8'hAA, 1'b1, 2'd3, 2'd3};
    dir[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 2'd2};

    rst_n = 1'b0; wr_en = 1'b0; inc_en = 1'b0; dec_en = 1'b0; oe = 1'b0;
    wr_addr = 2'd0; rd_addr = 2'd0; dbg_addr = 2'd0; wr_data = 8'h00;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step = 0;

    for (int k = 0; k < 14; k++) begin
      @(posedge clk);
      model_edge();
      #1 apply(dir[k], step);
      step++;
    end

    for (int k = 0; k < 800; k++) begin
      @(posedge clk);
      model_edge();
      #1;
      s.rst_n = ($urandom_range(0, 29) != 0) || !rst_n;
      s.wr    = ($urandom_range(0, 9) < 3) && s.rst_n;
      s.inc   = ($urandom_range(0, 9) < 2);
      s.dec   = ($urandom_range(0, 9) < 2);
      s.wa    = 2'($urandom_range(0, 3));
      s.wd    = ($urandom_range(0, 5) == 0) ? 8'hFF : 8'($urandom);
      s.oe    = ($urandom_range(0, 3) != 0);
      s.ra    = 2'($urandom_range(0, 3));
      s.da    = 2'($urandom_range(0, 3));
      apply(s, step);
      step++;
    end

    wait_cnt = 0;
    while (sb_q.size() > 0 && wait_cnt < 5) begin
      @(negedge clk);
      wait_cnt++;
    end
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_reg_file.md
# bus_reg_file

Parametrised bank of DEPTH general-purpose registers, each WIDTH bits, sitting between the CPU's shared data bus and the control unit. It is the successor to the single 8-bit bus register. It adds a clock-synchronous load, asynchronous active-low reset, in-place increment/decrement (PC/SP style), an addressed tri-state bus driver and an always-driven debug read port. One instance replaces the separate A/B/PC/MAR register instances.

## Interface
Parameters:
- WIDTH, 8, bits per register (≥2)
- DEPTH, 4, number of registers (≥2)
- AW, $clog2(DEPTH), address width (derived; not overridden)

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  load wr_data into register wr_addr
- inc_en  in  1  increment register wr_addr by 1
- dec_en  in  1  decrement register wr_addr by 1
- wr_addr  in  AW  target register for wr/inc/dec
- wr_data  in  WIDTH  bus value to load
- oe  in  1  drive register rd_addr onto bus_out
- rd_addr  in  AW  register placed on bus
- bus_out  out  WIDTH  tri-state bus driver; all bits Z when oe=0
- dbg_addr  in  AW  debug/monitor select
- dbg_data  out  WIDTH  register dbg_addr, always driven
- rd_zero  out  1  1 when register rd_addr == 0 (valid regardless of oe)
- err_multi  out  1  registered sticky flag: more than one of wr_en/inc_en/dec_en seen high in a cycle

## Operation
- Reset (rst_n=0, asynchronous): all registers = 0 and err_multi = 0 immediately, without waiting for clk. With oe=0, bus_out = Z; with oe=1, bus_out = 0; dbg_data = 0; rd_zero = 1.
- Rising edge, reset released: exactly one update to register wr_addr, priority wr_en > inc_en > dec_en.
  - wr_en: reg ← wr_data.
  - inc_en: reg ← reg+1 modulo 2^WIDTH (all-ones wraps to 0).
  - dec_en: reg ← reg−1 modulo 2^WIDTH (0 wraps to all-ones).
  - none: hold.
- Registers other than wr_addr always hold.
- err_multi is set on an edge where two or more of the three enables are high. It clears only on reset. The priority update still happens.
- Addresses ≥ DEPTH (non-power-of-2 DEPTH):
  - Writes are ignored.
  - Reads return 0 on bus_out, dbg_data and rd_zero logic.
- Reads are combinational from the register array: bus_out, dbg_data and rd_zero follow rd_addr/dbg_addr/oe within the same cycle.
- Release of reset mid-cycle: the first update happens on the first rising edge where rst_n=1.

## Timing
- Write/inc/dec latency: result visible on read ports immediately after the capturing edge, i.e. one cycle.
- Read latency: 0 cycles (combinational). oe→bus_out enable/disable is combinational; no bus hold.
- Same-cycle read of the register being updated returns the old value unless BUS_REG_FILE_BYPASS_EN is defined (see below).
- Control inputs must be stable around the rising edge. No handshake; every enable is single-cycle, consumed on that edge.

## Configuration
- BUS_REG_FILE_BYPASS_EN:
  - Defined: when wr_en=1 and rd_addr==wr_addr (valid address), bus_out (if oe) and rd_zero reflect wr_data in the same cycle. The same applies to dbg_data when dbg_addr==wr_addr. inc/dec are not bypassed.
  - Undefined: no bypass; reads always show stored contents.

## Test plan
WIDTH=8, DEPTH=4 unless stated.
- Reset: drive rst_n=0 mid-cycle after loading r1=0x5A → r1 reads 0x00 with no clock edge; oe=0 gives bus_out=ZZ; rd_zero=1; err_multi=0.
- Load/readback: wr_en, addr 2, data 0xC3; next cycle oe=1, rd_addr=2 → bus_out=0xC3, rd_zero=0. Set oe=0 → bus_out=Z; dbg_addr=2 still gives 0xC3.
- Wrap:
  - r0=0xFF, inc_en one edge → 0x00, rd_zero=1.
  - dec_en one edge → 0xFF.
- Priority/error: wr_en=1, inc_en=1, addr 1, data 0x10 → r1=0x10 (not 0x11); err_multi=1 and stays 1 until reset.
- Bypass: wr_en, addr 3, data 0x77, oe=1, rd_addr=3 in the same cycle.
  - Without the macro: bus_out = old value 0x00.
  - With BUS_REG_FILE_BYPASS_EN: bus_out = 0x77 before the edge.
- Non-power-of-2: DEPTH=3, wr_en to addr 3 with 0xAA → r0..r2 unchanged; rd_addr=3, oe=1 → bus_out=0x00.
